// File: rtl/dram_cache_pkg.sv
// Shared types for the DRAM cache controller read-address path.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package dram_cache_pkg;

  localparam int AR_ADDR_W = `AXI_ADDR_WIDTH;
  localparam int AR_ID_W   = `AXI_ID_WIDTH;
  localparam int AR_LEN_W  = 8;

  typedef enum logic {
    SRC_LOOKUP = 1'b0,
    SRC_FILL   = 1'b1
  } ar_src_e;

  typedef struct packed {
    logic [AR_ID_W-1:0]   id;
    logic [AR_ADDR_W-1:0] addr;
    logic [AR_LEN_W-1:0]  len;
  } ar_req_t;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } arb_state_e;

endpackage

// File: rtl/dram_ar_arbiter_cnt.sv
// Per-source in-flight burst counter with limit and underflow flags.
module ar_outstanding_cnt #(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic limit_o,
  output logic uflow_o
);

  localparam int W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [W-1:0] LIM = W'(MAX_OUTSTANDING);

  logic [W-1:0] cnt_q, cnt_d;

  assign limit_o = (cnt_q >= LIM);
  assign uflow_o = dec_i & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i & ~dec_i)
      cnt_d = cnt_q + W'(1);
    else if (dec_i & ~inc_i & (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dram_ar_arbiter.sv
// Lookup/fill AR arbiter with one-entry output stage.
// DRAM_AR_STARVE_GUARD_EN adds the fill starvation guard.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module dram_ar_arbiter
  import dram_cache_pkg::*;
#(
  parameter int ADDR_WIDTH      = `AXI_ADDR_WIDTH,
  parameter int ID_WIDTH        = `AXI_ID_WIDTH,
  parameter int MAX_OUTSTANDING = 16,
  parameter int STARVE_THR      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   tl_arid_i,
  input  logic [ADDR_WIDTH-1:0] tl_araddr_i,
  input  logic [7:0]            tl_arlen_i,
  input  logic                  tl_arvalid_i,
  output logic                  tl_arready_o,
  input  logic [ID_WIDTH-1:0]   fl_arid_i,
  input  logic [ADDR_WIDTH-1:0] fl_araddr_i,
  input  logic [7:0]            fl_arlen_i,
  input  logic                  fl_arvalid_i,
  output logic                  fl_arready_o,
  output logic [ID_WIDTH:0]     arid_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [7:0]            arlen_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic                  rdone_i,
  input  logic                  rdone_src_i,
  output logic                  err_o
);

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic                  err_q, err_d;

  logic slot_free, accept;
  logic tl_elig, fl_elig, fl_win;
  logic tl_gnt, fl_gnt, starve_hit;
  logic tl_lim, fl_lim, tl_uf, fl_uf;
  logic tl_dec, fl_dec;

  assign slot_free = (state_q == ST_IDLE) | arready_i;
  assign tl_elig   = tl_arvalid_i & ~tl_lim;
  assign fl_elig   = fl_arvalid_i & ~fl_lim;
  assign fl_win    = fl_elig & (~tl_elig | starve_hit);
  assign tl_gnt    = rst_n & slot_free & tl_elig & ~fl_win;
  assign fl_gnt    = rst_n & slot_free & fl_win;
  assign accept    = tl_gnt | fl_gnt;

  assign tl_arready_o = tl_gnt;
  assign fl_arready_o = fl_gnt;

  assign fl_dec = rdone_i & (ar_src_e'(rdone_src_i) == SRC_FILL);
  assign tl_dec = rdone_i & (ar_src_e'(rdone_src_i) == SRC_LOOKUP);

  ar_outstanding_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_tl_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (tl_gnt),
    .dec_i  (tl_dec),
    .limit_o(tl_lim),
    .uflow_o(tl_uf)
  );

  ar_outstanding_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_fl_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (fl_gnt),
    .dec_i  (fl_dec),
    .limit_o(fl_lim),
    .uflow_o(fl_uf)
  );

`ifdef DRAM_AR_STARVE_GUARD_EN
  localparam logic [7:0] THR = 8'(STARVE_THR);
  logic [7:0] starve_q, starve_d;

  assign starve_hit = (starve_q == THR);

  // Run length of lookup wins while a fill sits waiting.
  always_comb begin
    starve_d = starve_q;
    if (~fl_elig | fl_gnt)
      starve_d = '0;
    else if (tl_gnt & (starve_q != THR))
      starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  logic unused_thr;
  assign starve_hit = 1'b0;
  assign unused_thr = ^(8'(STARVE_THR));
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    err_d   = err_q | tl_uf | fl_uf;
    if (accept) begin
      state_d = ST_HOLD;
      id_d    = fl_gnt ? {SRC_FILL, fl_arid_i}
                       : {SRC_LOOKUP, tl_arid_i};
      addr_d  = fl_gnt ? fl_araddr_i : tl_araddr_i;
      len_d   = fl_gnt ? fl_arlen_i : tl_arlen_i;
    end else if ((state_q == ST_HOLD) & arready_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign arvalid_o = (state_q == ST_HOLD);
  assign arid_o    = id_q;
  assign araddr_o  = addr_q;
  assign arlen_o   = len_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_dram_ar_arbiter.sv
// Randomized bench for dram_ar_arbiter against a behavioural model.
module tb_dram_ar_arbiter;

  localparam int AW   = 32;
  localparam int IW   = 4;
  localparam int MAXO = 2;
  localparam int THR  = 3;
`ifdef DRAM_AR_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [IW-1:0] tl_id, fl_id;
  logic [AW-1:0] tl_addr, fl_addr;
  logic [7:0]    tl_len, fl_len;
  logic          tl_v, fl_v;
  logic          tl_arready_o, fl_arready_o;
  logic [IW:0]   arid_o;
  logic [AW-1:0] araddr_o;
  logic [7:0]    arlen_o;
  logic          arvalid_o;
  logic          arready;
  logic          rdone, rdone_src;
  logic          err_o;

  dram_ar_arbiter #(
    .ADDR_WIDTH     (AW),
    .ID_WIDTH       (IW),
    .MAX_OUTSTANDING(MAXO),
    .STARVE_THR     (THR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tl_arid_i   (tl_id),
    .tl_araddr_i (tl_addr),
    .tl_arlen_i  (tl_len),
    .tl_arvalid_i(tl_v),
    .tl_arready_o(tl_arready_o),
    .fl_arid_i   (fl_id),
    .fl_araddr_i (fl_addr),
    .fl_arlen_i  (fl_len),
    .fl_arvalid_i(fl_v),
    .fl_arready_o(fl_arready_o),
    .arid_o      (arid_o),
    .araddr_o    (araddr_o),
    .arlen_o     (arlen_o),
    .arvalid_o   (arvalid_o),
    .arready_i   (arready),
    .rdone_i     (rdone),
    .rdone_src_i (rdone_src),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference state
  bit          m_vld;
  logic [IW:0] m_id;
  logic [AW-1:0] m_addr;
  logic [7:0]  m_len;
  int          m_cnt[2];
  int          m_starve;
  bit          m_err;
  bit          m_el1;
  bit          e_g0, e_g1;
  bit          auto_rd;
  int          nfill;

  task automatic predict();
    bit free, el0, pf;
    free   = !m_vld || arready;
    el0    = tl_v && (m_cnt[0] < MAXO);
    m_el1  = fl_v && (m_cnt[1] < MAXO);
    pf     = m_el1 && (!el0 || (GUARD && m_starve == THR));
    e_g0   = rst_n && free && el0 && !pf;
    e_g1   = rst_n && free && pf;
  endtask

  task automatic update();
    bit inc, dec;
    if (!rst_n) begin
      m_vld = 0; m_id = '0; m_addr = '0; m_len = '0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_starve = 0; m_err = 0;
    end else begin
      if (e_g0 || e_g1) begin
        m_vld  = 1;
        m_id   = e_g1 ? {1'b1, fl_id} : {1'b0, tl_id};
        m_addr = e_g1 ? fl_addr : tl_addr;
        m_len  = e_g1 ? fl_len : tl_len;
      end else if (m_vld && arready) begin
        m_vld = 0;
      end
      for (int s = 0; s < 2; s++) begin
        inc = (s == 1) ? e_g1 : e_g0;
        dec = rdone && (int'(rdone_src) == s);
        if (dec && m_cnt[s] == 0) m_err = 1;
        if (inc && !dec) m_cnt[s]++;
        else if (dec && !inc && m_cnt[s] > 0) m_cnt[s]--;
      end
      if (!m_el1 || e_g1) m_starve = 0;
      else if (e_g0 && m_starve < THR) m_starve++;
    end
  endtask

  // One clock: compare at negedge+1, advance model on posedge.
  task automatic cyc();
    if (auto_rd) begin
      rdone = 0;
      if (m_cnt[0] > 0) begin
        rdone = 1; rdone_src = 0;
      end else if (m_cnt[1] > 0) begin
        rdone = 1; rdone_src = 1;
      end
    end
    #1;
    predict();
    check("tl_rdy", tl_arready_o, e_g0);
    check("fl_rdy", fl_arready_o, e_g1);
    check("arvalid", arvalid_o, m_vld);
    check("err", err_o, m_err);
    if (m_vld) begin
      check("arid", arid_o, m_id);
      check("araddr", araddr_o, m_addr);
      check("arlen", arlen_o, m_len);
    end
    if (fl_arready_o) nfill++;
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; arready = 0; rdone = 0; rdone_src = 0;
    tl_v = 1; fl_v = 0; auto_rd = 0;
    tl_id = 1; fl_id = 2; tl_addr = '0; fl_addr = '0;
    tl_len = '0; fl_len = '0;
    update();
    @(negedge clk);
    #1 check("rst_tl_rdy", tl_arready_o, 0);
    cyc(); cyc();
    check("rst_arvalid", arvalid_o, 0);
    check("rst_arid", arid_o, 0);
    check("rst_araddr", araddr_o, 0);
    check("rst_arlen", arlen_o, 0);
    check("rst_err", err_o, 0);

    rst_n = 1; tl_v = 0; arready = 1; auto_rd = 1;
    for (int i = 1; i <= 4; i++) begin
      tl_v = 1; tl_id = IW'(i);
      tl_addr = 32'h100 * i; tl_len = 8'(i);
      cyc();
      check("b2b_id", arid_o, (IW+1)'(i));
      check("b2b_vld", arvalid_o, 1);
    end
    tl_v = 0;
    repeat (3) cyc();

    nfill = 0;
    tl_v = 1; fl_v = 1; tl_id = 3; fl_id = 4;
    repeat (8) begin
      tl_addr = $urandom; fl_addr = $urandom;
      cyc();
    end
    check("starve_fills", nfill, GUARD ? 2 : 0);
    tl_v = 0; fl_v = 0;
    repeat (4) cyc();

    tl_v = 1; tl_id = 5; tl_addr = 32'h1000; tl_len = 8'h3;
    cyc();
    tl_id = 6; tl_addr = 32'h2000; arready = 0;
    repeat (5) begin
      #1 check("stall_tl_rdy", tl_arready_o, 0);
      cyc();
      check("stall_addr", araddr_o, 32'h1000);
      check("stall_id", arid_o, 5'h05);
    end
    arready = 1;
    cyc();
    check("drain_addr", araddr_o, 32'h2000);
    tl_v = 0;
    repeat (4) cyc();

    auto_rd = 0; rdone = 0;
    fl_v = 1; fl_id = 9; fl_addr = 32'h3000;
    repeat (2) cyc();
    #1 check("lim_fl_rdy", fl_arready_o, 0);
    cyc();
    rdone = 1; rdone_src = 1;
    #1 check("lim_fl_rdy2", fl_arready_o, 0);
    cyc();
    rdone = 0;
    #1 check("lim_fl_rdy3", fl_arready_o, 1);
    cyc();
    fl_v = 0;

    tl_v = 1; tl_id = 2;
    cyc();
    rdone = 1; rdone_src = 0;
    cyc();
    rdone = 0;
    cyc();
    #1 check("same_tl_rdy", tl_arready_o, 0);
    tl_v = 0;
    cyc();
    auto_rd = 1;
    repeat (6) cyc();

    auto_rd = 0; rdone = 1; rdone_src = 1;
    cyc();
    rdone = 0;
    check("err_set", err_o, 1);
    cyc();
    check("err_sticky", err_o, 1);

    tl_v = 1; tl_id = 4'hA; tl_addr = 32'hABC0; arready = 0;
    cyc();
    tl_v = 0; rst_n = 0;
    cyc();
    rst_n = 1;
    check("rst2_vld", arvalid_o, 0);
    check("rst2_addr", araddr_o, 0);
    check("rst2_id", arid_o, 0);
    check("rst2_err", err_o, 0);
    tl_v = 1; tl_id = 7; tl_addr = 32'h40; arready = 1;
    cyc();
    check("post_rst_id", arid_o, 5'h07);
    check("post_rst_vld", arvalid_o, 1);
    tl_v = 0; auto_rd = 1;
    repeat (3) cyc();

    auto_rd = 0;
    repeat (3000) begin
      int s;
      tl_v    = 1'($urandom_range(0, 1));
      fl_v    = 1'($urandom_range(0, 1));
      tl_id   = IW'($urandom); fl_id = IW'($urandom);
      tl_addr = $urandom; fl_addr = $urandom;
      tl_len  = 8'($urandom); fl_len = 8'($urandom);
      arready = ($urandom_range(0, 3) != 0);
      rdone   = 0;
      s = int'($urandom_range(0, 1));
      if (m_cnt[s] > 0 && $urandom_range(0, 1) == 1) begin
        rdone = 1; rdone_src = s[0];
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
